// File: rtl/mem_arb_pkg.sv
// Shared constants for the memory port arbiter: FSM encoding, default
// timeout length and the data word returned when memory never answers.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_IBUSY = 2'd1;
  localparam logic [1:0] ST_DBUSY = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int MAX_WAIT_DEF = 15;

  // Every bit of the timeout data word takes this value.
  localparam logic TIMEOUT_FILL = 1'b0;

  function automatic logic is_busy(input logic [1:0] st);
    return (st == ST_IBUSY) || (st == ST_DBUSY);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester (IF/MEM stage) and memory-side signals of the arbiter.
// slave is the arbiter's view, master is the surrounding system's view.
interface mem_port_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              IReq;
  logic [DATA_W-1:0] IAddr;
  logic              DRead;
  logic              DWrite;
  logic [DATA_W-1:0] DAddr;
  logic [DATA_W-1:0] DWData;
  logic [DATA_W-1:0] IData;
  logic [DATA_W-1:0] DRData;
  logic              IValid;
  logic              DValid;
  logic              StallIF;
  logic              StallMEM;
  logic              MemReq;
  logic              MemWE;
  logic [DATA_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWData;
  logic [DATA_W-1:0] MemRData;
  logic              MemAck;
  logic              Err;

  modport slave (
    input  IReq, IAddr, DRead, DWrite, DAddr, DWData, MemRData, MemAck,
    output IData, DRData, IValid, DValid, StallIF, StallMEM,
           MemReq, MemWE, MemAddr, MemWData, Err
  );

  modport master (
    output IReq, IAddr, DRead, DWrite, DAddr, DWData, MemRData, MemAck,
    input  IData, DRData, IValid, DValid, StallIF, StallMEM,
           MemReq, MemWE, MemAddr, MemWData, Err
  );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts busy cycles without a memory acknowledge; expired flags the cycle
// in which one more unacknowledged cycle would reach MAX_WAIT.
module mem_wait_timer
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != CNT_W'(MAX_WAIT))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign expired = enable && (cnt_q == CNT_W'(MAX_WAIT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data load/store,
// data side first, with per-transaction timeout and a sticky error flag.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              CLK,
  input  logic              Reset_L,
  mem_port_arbiter_if.slave bus
);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] idata_q, idata_d;
  logic [DATA_W-1:0] drdata_q, drdata_d;
  logic              we_q, we_d;
  logic              load_q, load_d;
  logic              ivalid_q, ivalid_d;
  logic              dvalid_q, dvalid_d;
  logic              err_q, err_d;

  logic              busy;
  logic              grant;
  logic              expired;
  logic              stall_mem;
  logic [DATA_W-1:0] ret_data;

  assign busy     = is_busy(state_q);
  assign ret_data = bus.MemAck ? bus.MemRData : {DATA_W{TIMEOUT_FILL}};

  mem_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk     (CLK),
    .rst_n   (Reset_L),
    .clear   (grant),
    .enable  (busy && !bus.MemAck),
    .expired (expired)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    idata_d  = idata_q;
    drdata_d = drdata_q;
    we_d     = we_q;
    load_d   = load_q;
    err_d    = err_q;
    ivalid_d = 1'b0;
    dvalid_d = 1'b0;
    grant    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.DRead || bus.DWrite) begin
          // A simultaneous read+write is resolved as a store and flagged.
          state_d = ST_DBUSY;
          grant   = 1'b1;
          addr_d  = bus.DAddr;
          wdata_d = bus.DWData;
          we_d    = bus.DWrite;
          load_d  = !bus.DWrite;
          if (bus.DRead && bus.DWrite) begin
            err_d = 1'b1;
          end
        end else if (bus.IReq) begin
          state_d = ST_IBUSY;
          grant   = 1'b1;
          addr_d  = bus.IAddr;
          wdata_d = '0;
          we_d    = 1'b0;
          load_d  = 1'b0;
        end
      end

      ST_IBUSY, ST_DBUSY: begin
        if (bus.MemAck || expired) begin
          state_d = ST_DONE;
          we_d    = 1'b0;
          if (!bus.MemAck) begin
            err_d = 1'b1;
          end
          if (state_q == ST_DBUSY) begin
            dvalid_d = 1'b1;
            if (load_q) begin
              drdata_d = ret_data;
            end
          end else begin
            ivalid_d = 1'b1;
            idata_d  = ret_data;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      idata_q  <= '0;
      drdata_q <= '0;
      we_q     <= 1'b0;
      load_q   <= 1'b0;
      ivalid_q <= 1'b0;
      dvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      idata_q  <= idata_d;
      drdata_q <= drdata_d;
      we_q     <= we_d;
      load_q   <= load_d;
      ivalid_q <= ivalid_d;
      dvalid_q <= dvalid_d;
      err_q    <= err_d;
    end
  end

  assign stall_mem    = (bus.DRead || bus.DWrite) && !dvalid_q;
  assign bus.StallMEM = stall_mem;
  assign bus.StallIF  = (bus.IReq && !ivalid_q) || stall_mem;
  assign bus.MemReq   = busy;
  assign bus.MemWE    = we_q;
  assign bus.MemAddr  = addr_q;
  assign bus.MemWData = wdata_q;
  assign bus.IData    = idata_q;
  assign bus.DRData   = drdata_q;
  assign bus.IValid   = ivalid_q;
  assign bus.DValid   = dvalid_q;
  assign bus.Err      = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, reset corner cases and
// randomized request sets checked against a transaction-level timing model.
module tb_mem_port_arbiter;

  localparam int MW = 15;

  typedef struct {
    logic        ireq;
    logic        dread;
    logic        dwrite;
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ackw;
  } req_t;

  typedef struct {
    bit          do_rst;
    req_t        rq;
    logic [31:0] e_addr;
    logic        e_we;
    int          e_lat1;
    int          e_lat2;
    logic [31:0] e_data;
    logic        e_err;
  } vec_t;

  logic CLK;
  logic Reset_L;

  mem_port_arbiter_if #(.DATA_W(32)) bus ();

  mem_port_arbiter #(
    .DATA_W   (32),
    .MAX_WAIT (MW)
  ) dut (
    .CLK     (CLK),
    .Reset_L (Reset_L),
    .bus     (bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_idata;
  logic [31:0] m_drdata;
  logic        m_err;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.IReq     = 1'b0;
    bus.IAddr    = '0;
    bus.DRead    = 1'b0;
    bus.DWrite   = 1'b0;
    bus.DAddr    = '0;
    bus.DWData   = '0;
    bus.MemRData = '0;
    bus.MemAck   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    Reset_L = 1'b0;
    drive_idle();
    repeat (2) @(negedge CLK);
    #1;
    chk1("rst MemReq", bus.MemReq, 1'b0);
    chk1("rst MemWE", bus.MemWE, 1'b0);
    chk32("rst MemAddr", bus.MemAddr, 32'h0);
    chk32("rst MemWData", bus.MemWData, 32'h0);
    chk32("rst IData", bus.IData, 32'h0);
    chk32("rst DRData", bus.DRData, 32'h0);
    chk1("rst IValid", bus.IValid, 1'b0);
    chk1("rst DValid", bus.DValid, 1'b0);
    chk1("rst Err", bus.Err, 1'b0);
    Reset_L  = 1'b1;
    m_idata  = '0;
    m_drdata = '0;
    m_err    = 1'b0;
  endtask

  // Model: data request served first, then fetch. Each transaction starts at
  // cycle s (seen in IDLE), is busy for eff+1 cycles, completes at s+2+eff,
  // and the next one is seen at IDLE re-entry one cycle later.
  task automatic run_set(input req_t rq, input bit junk,
                         output int lat1, output int lat2,
                         output logic [31:0] addr1, output logic we1,
                         output logic [31:0] data1, output logic err_o);
    int nt;
    int st[2];
    int dn[2];
    bit od[2];
    int eff;
    bit tout;
    bit pi;
    bit pd;
    int last;
    bit got_busy;
    eff  = (rq.ackw >= MW) ? MW - 1 : rq.ackw;
    tout = (rq.ackw >= MW);
    nt   = 0;
    if (rq.dread || rq.dwrite) begin od[nt] = 1'b1; nt++; end
    if (rq.ireq) begin od[nt] = 1'b0; nt++; end
    for (int k = 0; k < nt; k++) begin
      st[k] = (k == 0) ? 0 : dn[k-1] + 1;
      dn[k] = st[k] + 2 + eff;
    end
    pi = rq.ireq;
    pd = rq.dread || rq.dwrite;
    lat1 = -1; lat2 = -1; addr1 = 'x; we1 = 1'bx; data1 = 'x;
    got_busy = 1'b0;
    last = (nt == 0) ? -1 : dn[nt-1];
    for (int c = 0; c <= last; c++) begin
      int k;
      int ph;
      int j;
      bit ev_i;
      bit ev_d;
      bit sm;
      k = (nt > 1 && c >= st[1]) ? 1 : 0;
      if (c == st[k]) ph = 0;
      else if (c == dn[k]) ph = 2;
      else ph = 1;
      j = c - st[k] - 1;
      @(negedge CLK);
      bus.IReq   = pi;
      bus.DRead  = pd && rq.dread;
      bus.DWrite = pd && rq.dwrite;
      if (junk && ph != 0) begin
        bus.IAddr = $urandom; bus.DAddr = $urandom; bus.DWData = $urandom;
      end else begin
        bus.IAddr = rq.iaddr; bus.DAddr = rq.daddr; bus.DWData = rq.wdata;
      end
      if (ph == 1) begin
        bus.MemAck   = (j == rq.ackw);
        bus.MemRData = (j == rq.ackw) ? rq.rdata : $urandom;
      end else begin
        bus.MemAck   = junk ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.MemRData = $urandom;
      end
      ev_i = (ph == 2) && !od[k];
      ev_d = (ph == 2) && od[k];
      if (ph == 2) begin
        if (!od[k]) m_idata = tout ? 32'h0 : rq.rdata;
        else if (!rq.dwrite) m_drdata = tout ? 32'h0 : rq.rdata;
        if (tout) m_err = 1'b1;
      end
      #1;
      chk1("MemReq", bus.MemReq, ph == 1);
      if (ph == 1) begin
        chk32("MemAddr", bus.MemAddr, od[k] ? rq.daddr : rq.iaddr);
        chk1("MemWE busy", bus.MemWE, od[k] && rq.dwrite);
        if (od[k] && rq.dwrite) chk32("MemWData", bus.MemWData, rq.wdata);
        if (!got_busy) begin
          addr1 = bus.MemAddr; we1 = bus.MemWE; got_busy = 1'b1;
        end
      end else begin
        chk1("MemWE idle", bus.MemWE, 1'b0);
      end
      chk1("IValid", bus.IValid, ev_i);
      chk1("DValid", bus.DValid, ev_d);
      chk32("IData", bus.IData, m_idata);
      chk32("DRData", bus.DRData, m_drdata);
      chk1("Err", bus.Err, m_err);
      sm = (bus.DRead || bus.DWrite) && !ev_d;
      chk1("StallMEM", bus.StallMEM, sm);
      chk1("StallIF", bus.StallIF, (bus.IReq && !ev_i) || sm);
      if (bus.IValid || bus.DValid) begin
        if (lat1 < 0) lat1 = c;
        else if (lat2 < 0) lat2 = c;
      end
      if (ph == 2) begin
        if (k == 0) data1 = od[k] ? bus.DRData : bus.IData;
        if (od[k]) pd = 1'b0;
        else pi = 1'b0;
      end
      if (ph == 0 && od[k] && rq.dread && rq.dwrite) m_err = 1'b1;
    end
    @(negedge CLK);
    drive_idle();
    bus.MemAck = junk ? 1'($urandom_range(0, 1)) : 1'b0;
    #1;
    chk1("idle MemReq", bus.MemReq, 1'b0);
    chk1("idle IValid", bus.IValid, 1'b0);
    chk1("idle DValid", bus.DValid, 1'b0);
    chk1("idle StallIF", bus.StallIF, 1'b0);
    chk1("idle StallMEM", bus.StallMEM, 1'b0);
    err_o = bus.Err;
  endtask

  initial begin
    vec_t        vt[7];
    int          lat1;
    int          lat2;
    logic [31:0] addr1;
    logic        we1;
    logic [31:0] data1;
    logic        err_o;

    vt[0] = '{0, '{1, 0, 0, 32'h40, 32'h0, 32'h0, 32'h8C220004, 0},
              32'h40, 1'b0, 2, -1, 32'h8C220004, 1'b0};
    vt[1] = '{0, '{1, 1, 0, 32'h44, 32'h100, 32'h0, 32'h11112222, 0},
              32'h100, 1'b0, 2, 5, 32'h11112222, 1'b0};
    vt[2] = '{0, '{0, 0, 1, 32'h0, 32'h200, 32'hDEADBEEF, 32'h5555AAAA, 3},
              32'h200, 1'b1, 5, -1, 32'h11112222, 1'b0};
    vt[3] = '{0, '{0, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0BADF00D, 14},
              32'h0, 1'b0, 16, -1, 32'h0BADF00D, 1'b0};
    vt[4] = '{0, '{0, 1, 0, 32'h0, 32'h80, 32'h0, 32'h99999999, 99},
              32'h80, 1'b0, 16, -1, 32'h0, 1'b1};
    vt[5] = '{1, '{0, 1, 1, 32'h0, 32'h204, 32'h12345678, 32'h77777777, 1},
              32'h204, 1'b1, 3, -1, 32'h0, 1'b1};
    vt[6] = '{0, '{1, 0, 0, 32'hFFFFFFFC, 32'h0, 32'h0, 32'hFFFFFFFF, 2},
              32'hFFFFFFFC, 1'b0, 4, -1, 32'hFFFFFFFF, 1'b1};

    Reset_L = 1'b0;
    drive_idle();
    do_reset();

    for (int i = 0; i < 7; i++) begin
      if (vt[i].do_rst) do_reset();
      run_set(vt[i].rq, 1'b0, lat1, lat2, addr1, we1, data1, err_o);
      chk32($sformatf("v%0d lat1", i), 32'(lat1), 32'(vt[i].e_lat1));
      chk32($sformatf("v%0d lat2", i), 32'(lat2), 32'(vt[i].e_lat2));
      chk32($sformatf("v%0d addr", i), addr1, vt[i].e_addr);
      chk1($sformatf("v%0d we", i), we1, vt[i].e_we);
      chk32($sformatf("v%0d data", i), data1, vt[i].e_data);
      chk1($sformatf("v%0d err", i), err_o, vt[i].e_err);
    end

    // Reset in the middle of a load; a late acknowledge must be ignored.
    @(negedge CLK);
    bus.DRead = 1'b1;
    bus.DAddr = 32'h300;
    @(negedge CLK);
    #1;
    chk1("midrst MemReq before", bus.MemReq, 1'b1);
    chk32("midrst MemAddr before", bus.MemAddr, 32'h300);
    Reset_L = 1'b0;
    @(negedge CLK);
    Reset_L      = 1'b1;
    bus.DRead    = 1'b0;
    bus.MemAck   = 1'b1;
    bus.MemRData = 32'hCAFEF00D;
    #1;
    chk1("midrst MemReq", bus.MemReq, 1'b0);
    chk1("midrst Err", bus.Err, 1'b0);
    chk32("midrst MemAddr", bus.MemAddr, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      #1;
      chk1("midrst DValid", bus.DValid, 1'b0);
      chk1("midrst MemReq idle", bus.MemReq, 1'b0);
      chk32("midrst DRData", bus.DRData, 32'h0);
    end
    bus.MemAck = 1'b0;
    m_idata  = '0;
    m_drdata = '0;
    m_err    = 1'b0;

    for (int i = 0; i < 48; i++) begin
      req_t rq;
      int   kind;
      int   r;
      bit   coin;
      if (i % 12 == 0) do_reset();
      kind = $urandom_range(0, 4);
      coin = 1'($urandom_range(0, 1));
      rq.ireq   = (kind == 0) || (kind == 4);
      rq.dread  = (kind == 1) || (kind == 3) || (kind == 4 && coin);
      rq.dwrite = (kind == 2) || (kind == 3) || (kind == 4 && !coin);
      rq.iaddr  = $urandom;
      rq.daddr  = $urandom;
      rq.wdata  = $urandom;
      rq.rdata  = $urandom;
      r = $urandom_range(0, 9);
      if (r < 7) rq.ackw = $urandom_range(0, 4);
      else if (r == 7) rq.ackw = MW - 1;
      else rq.ackw = MW + $urandom_range(0, 2);
      run_set(rq, 1'b1, lat1, lat2, addr1, we1, data1, err_o);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data/address width.
REQ-002 SHALL have parameter MAX_WAIT, default 15: busy cycles allowed without MemAck before timeout.
REQ-003 SHALL have port CLK, input, 1: sole clock; all state updates on rising edge.
REQ-004 SHALL have port Reset_L, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port IReq, input, 1: fetch request from IF stage.
REQ-006 SHALL have port IAddr, input, DATA_W: fetch address.
REQ-007 SHALL have port DRead, input, 1: load request (MemRead from control).
REQ-008 SHALL have port DWrite, input, 1: store request (MemWrite from control).
REQ-009 SHALL have ports DAddr and DWData, input, DATA_W each: data address and store data.
REQ-010 SHALL have ports IData and DRData, output, DATA_W each: returned fetch and load data.
REQ-011 SHALL have ports IValid and DValid, output, 1 each: one-cycle completion pulses.
REQ-012 SHALL have ports StallIF and StallMEM, output, 1 each: pipeline freeze requests.
REQ-013 SHALL have ports MemReq and MemWE, output, 1 each: memory request and write enable.
REQ-014 SHALL have ports MemAddr and MemWData, output, DATA_W each: memory address and write data.
REQ-015 SHALL have ports MemRData, input, DATA_W, and MemAck, input, 1: memory read data and completion.
REQ-016 SHALL have port Err, output, 1: sticky fault flag.

Function
REQ-017 SHALL implement FSM states IDLE, IBUSY, DBUSY, DONE.
REQ-018 IDLE: if DRead|DWrite then DBUSY, else if IReq then IBUSY, else stay; data has priority over fetch.
REQ-019 On grant, SHALL latch address, write data and MemWE (DWrite) into registers; MemAddr/MemWData/MemWE are driven only from these registers.
REQ-020 MemReq SHALL be high in every IBUSY/DBUSY cycle and low in IDLE/DONE.
REQ-021 IBUSY/DBUSY with MemAck high: capture MemRData into IData or DRData, then go to DONE.
REQ-022 DONE SHALL last exactly one cycle, pulse IValid (fetch) or DValid (load or store), make no grant, then go to IDLE.
REQ-023 Latency: request first seen in IDLE at cycle t, MemAck at t+1+w, gives valid at t+2+w; minimum is 2 cycles.
REQ-024 IData/DRData SHALL hold their value until the next capture of the same kind.
REQ-025 StallMEM SHALL equal (DRead|DWrite) & ~DValid, combinationally.
REQ-026 StallIF SHALL equal (IReq & ~IValid) | StallMEM, combinationally.
REQ-027 A wait counter SHALL clear on entry to IBUSY/DBUSY and increment each busy cycle without MemAck.
REQ-028 If the wait counter reaches MAX_WAIT without MemAck, SHALL go to DONE, return data 0, pulse the valid for the owner, and set Err.
REQ-029 DRead and DWrite both high in IDLE SHALL be treated as a store and SHALL set Err.
REQ-030 MemAck in IDLE or DONE SHALL be ignored.
REQ-031 Requester inputs SHALL be ignored while busy; the latched request is used.
REQ-032 Err SHALL stay high until reset.

Reset
REQ-033 Reset_L low at a rising edge SHALL force IDLE, wait counter 0, Err 0, IValid/DValid 0, MemReq/MemWE 0, latched address/data and IData/DRData 0.
REQ-034 Reset mid-transaction SHALL abandon the transaction with no valid pulse, and a later MemAck SHALL be ignored.

Structure
REQ-035 Shared package mem_arb_pkg SHALL hold the state encoding (2-bit), MAX_WAIT default and timeout data value (0).
REQ-036 The wait counter SHALL be sub-module mem_wait_timer (clear, enable, MAX_WAIT parameter, expired output); the rest stays in mem_port_arbiter.

Verification
REQ-037 IReq=1, IAddr=0x40, MemAck the first busy cycle, MemRData=0x8C220004 -> MemReq at t+1, IValid and IData=0x8C220004 at t+2, StallIF high t..t+1.
REQ-038 IReq and DRead together, DAddr=0x100 -> MemAddr=0x100 first, DValid; then fetch of IAddr granted with IValid 2 cycles after IDLE re-entry.
REQ-039 DWrite=1, DAddr=0x200, DWData=0xDEADBEEF, MemAck after 3 wait cycles -> MemWE=1 and MemWData=0xDEADBEEF for 4 cycles, DValid at t+5, Err=0.
REQ-040 DRead=1, MemAck never -> after MAX_WAIT=15 busy cycles DONE, DValid with DRData=0, Err=1 and held until reset.
REQ-041 Reset_L low during DBUSY, then MemAck -> IDLE, no DValid, MemReq=0, Err=0.
REQ-042 DRead=DWrite=1 -> store issued (MemWE=1), Err=1.
